dm_byte: RTL

Word-organised data memory for the MEM stage, sitting directly upstream of `MEM_EXT`. It performs byte, halfword and word stores with per-byte write enables. It returns the full aligned 32-bit word at the access address; that word drives `MEM_EXT.Din`, and `A[1:0]` drives `MEM_EXT.AO`. Misaligned and out-of-range stores are detected and suppressed.

---
 rtl/dm_byte.sv | 99 +++++++++
 1 files changed

// File: rtl/dm_byte.sv
// Word-organised data memory for the MEM stage: byte/halfword/word stores with
// per-byte enables, misaligned/out-of-range store suppression, full-word read.
module dm_byte #(
    parameter int          WORDS_LOG2 = 10,
    parameter logic [31:0] BASE       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic        MemWrite,
    input  logic [1:0]  SOp,
    output logic [31:0] RD,
    output logic [3:0]  BE,
    output logic        AdES,
    output logic        err_sticky,
    output logic [15:0] wr_count
);
    localparam int DEPTH = 1 << WORDS_LOG2;

    typedef enum logic [1:0] {
        SOP_SW  = 2'b00,
        SOP_SH  = 2'b01,
        SOP_SB  = 2'b10,
        SOP_RSV = 2'b11
    } sop_e;

    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           off;
    logic                  in_range;
    logic [WORDS_LOG2-1:0] idx;
    logic [3:0]            raw_be;
    logic [31:0]           lane_wd;
    logic                  misalign;
    logic [31:0]           word_d;
    logic                  err_d, err_q;
    logic [15:0]           cnt_d, cnt_q;

    always_comb begin
        off      = A - BASE;
        in_range = (off >> (WORDS_LOG2 + 2)) == 32'd0;
        idx      = off[WORDS_LOG2+1:2];
    end

    always_comb begin
        raw_be   = 4'b0000;
        lane_wd  = WD;
        misalign = 1'b0;
        case (sop_e'(SOp))
            SOP_SW: begin
                raw_be   = 4'b1111;
                misalign = A[1:0] != 2'b00;
            end
            SOP_SH: begin
                raw_be   = A[1] ? 4'b1100 : 4'b0011;
                lane_wd  = {2{WD[15:0]}};
                misalign = A[0];
            end
            SOP_SB: begin
                raw_be  = 4'b0001 << A[1:0];
                lane_wd = {4{WD[7:0]}};
            end
            default: raw_be = 4'b0000;
        endcase
    end

    // Reserved SOp has no enables, so it never faults and never writes.
    always_comb begin
        AdES = MemWrite && (raw_be != 4'b0000) && (misalign || !in_range);
        BE   = (MemWrite && !AdES && !reset) ? raw_be : 4'b0000;
        RD   = mem_q[idx];
        for (int b = 0; b < 4; b++) begin
            word_d[8*b +: 8] = BE[b] ? lane_wd[8*b +: 8] : RD[8*b +: 8];
        end
        err_d = err_q | AdES;
        cnt_d = cnt_q + {15'd0, BE != 4'b0000};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (BE != 4'b0000) begin
            mem_q[idx] <= word_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_sticky = err_q;
    assign wr_count   = cnt_q;
endmodule
